// File: rtl/inst_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_unit_if
// Description : Bundle of the fetch-stage signals. It carries the redirect
//               input, the instruction-SRAM read port and the fetch->decode
//               valid/ready handshake.
//               master : the fetch unit (drives the SRAM request and decode side)
//               slave  : environment (redirect source, SRAM, decode stage)
// Ports       : redirect_valid/redirect_pc  - load a new fetch PC, flush queue
//               inst_sram_en/addr/rdata     - 1-cycle latency SRAM read port
//               if_valid/if_pc/if_inst      - queue head presented to decode
//               id_ready                    - decode accepts the head
// Revision    : 1.0 - initial release
// ============================================================================
interface inst_fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
) ();
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              inst_sram_en;
  logic [ADDR_W-1:0] inst_sram_addr;
  logic [INST_W-1:0] inst_sram_rdata;
  logic              if_valid;
  logic [ADDR_W-1:0] if_pc;
  logic [INST_W-1:0] if_inst;
  logic              id_ready;

  modport master (
    input  redirect_valid, redirect_pc, inst_sram_rdata, id_ready,
    output inst_sram_en, inst_sram_addr, if_valid, if_pc, if_inst
  );

  modport slave (
    output redirect_valid, redirect_pc, inst_sram_rdata, id_ready,
    input  inst_sram_en, inst_sram_addr, if_valid, if_pc, if_inst
  );
endinterface
`default_nettype wire

// File: rtl/inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_unit
// Description : Instruction-fetch stage. Issues word-aligned reads to an
//               instruction SRAM with 1-cycle read latency, buffers returned
//               instructions together with their PCs in a FQ_DEPTH-entry
//               queue, and presents the queue head to decode via valid/ready.
//               A redirect flushes the queue, drops any in-flight response and
//               reloads the fetch PC.
// Ports       : clk  - clock, all state on the rising edge
//               rst  - asynchronous, active-high reset
//               bus  - inst_fetch_unit_if.master (redirect, SRAM, decode)
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                FQ_DEPTH = 2
) (
  input wire                clk,
  input wire                rst,
  inst_fetch_unit_if.master bus
);

  localparam int PTR_W = $clog2(FQ_DEPTH);
  localparam int CNT_W = $clog2(FQ_DEPTH + 1);

  localparam logic [ADDR_W-1:0] c_pc_step    = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] c_align_mask = ADDR_W'(3);
  localparam logic [PTR_W-1:0]  c_ptr_one    = PTR_W'(1);
  localparam logic [CNT_W-1:0]  c_cnt_one    = CNT_W'(1);
  localparam logic [CNT_W:0]    c_depth      = (CNT_W + 1)'(FQ_DEPTH);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]        r_state;
  logic [0:0]        w_state_next;

  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_req_pc;        // PC of the request whose data arrives this cycle
  logic              r_resp_pending;

  logic [ADDR_W-1:0] r_q_pc   [FQ_DEPTH];
  logic [INST_W-1:0] r_q_inst [FQ_DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_head_valid;
  logic              w_pop;
  logic              w_push;
  logic              w_issue;
  logic [CNT_W:0]    w_occupancy;
  logic [ADDR_W-1:0] w_redirect_target;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state (IDLE only lasts until the first edge out of reset)
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  w_state_next = S_RUN;
      S_RUN:   w_state_next = S_RUN;
      default: w_state_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs and issue/handshake decisions
  // --------------------------------------------------------------------------
  always_comb begin
    w_head_valid = (r_count != '0);
    w_pop        = w_head_valid && bus.id_ready && !bus.redirect_valid;
    w_push       = r_resp_pending && !bus.redirect_valid;
    // Entries that will be held after this edge if no new request is made.
    // A pop implies r_count >= 1, so this never underflows.
    w_occupancy  = {1'b0, r_count}
                 + {{CNT_W{1'b0}}, r_resp_pending}
                 - {{CNT_W{1'b0}}, w_pop};
    w_issue      = (r_state == S_RUN) && !bus.redirect_valid && (w_occupancy < c_depth);

    bus.inst_sram_en   = w_issue;
    bus.inst_sram_addr = r_fetch_pc;
    bus.if_valid       = w_head_valid && !bus.redirect_valid;
    bus.if_pc          = r_q_pc[r_rd_ptr];
    bus.if_inst        = r_q_inst[r_rd_ptr];
  end

  assign w_redirect_target = bus.redirect_pc & ~c_align_mask;

  // --------------------------------------------------------------------------
  // Fetch PC, response tracking and queue control
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc     <= RESET_PC;
      r_req_pc       <= RESET_PC;
      r_resp_pending <= 1'b0;
      r_rd_ptr       <= '0;
      r_wr_ptr       <= '0;
      r_count        <= '0;
    end else if (bus.redirect_valid) begin
      // Redirect wins over everything: flush and drop the in-flight response.
      r_fetch_pc     <= w_redirect_target;
      r_resp_pending <= 1'b0;
      r_rd_ptr       <= '0;
      r_wr_ptr       <= '0;
      r_count        <= '0;
    end else begin
      r_resp_pending <= w_issue;
      if (w_issue) begin
        r_req_pc   <= r_fetch_pc;
        r_fetch_pc <= r_fetch_pc + c_pc_step;   // wraps modulo 2^ADDR_W
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue storage: contents are only observed through a valid head, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_pc[r_wr_ptr]   <= r_req_pc;
      r_q_inst[r_wr_ptr] <= bus.inst_sram_rdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_fetch_unit
// Description : Self-checking bench for inst_fetch_unit. A queue-based
//               behavioural model of the fetch stage is compared with the DUT
//               on every cycle; directed scenarios add literal expectations.
//               A second instance with RESET_PC = 0xFFFFFFF8 covers PC wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_unit;

  localparam int              AW    = 32;
  localparam int              IW    = 32;
  localparam int              DEPTH = 2;
  localparam logic [AW-1:0]   RPC0  = 32'h0000_0000;
  localparam logic [AW-1:0]   RPC1  = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  inst_fetch_unit_if #(.ADDR_W(AW), .INST_W(IW)) bus0 ();
  inst_fetch_unit_if #(.ADDR_W(AW), .INST_W(IW)) bus1 ();

  inst_fetch_unit #(.ADDR_W(AW), .INST_W(IW), .RESET_PC(RPC0), .FQ_DEPTH(DEPTH)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.master)
  );
  inst_fetch_unit #(.ADDR_W(AW), .INST_W(IW), .RESET_PC(RPC1), .FQ_DEPTH(DEPTH)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.master)
  );

  // SRAM content is derived from the address, scrambled so PC and data differ.
  function automatic logic [IW-1:0] mem_data(input logic [AW-1:0] a);
    return a ^ 32'h5A00_00A5;
  endfunction

  always @(posedge clk) begin
    if (bus0.inst_sram_en) bus0.inst_sram_rdata <= mem_data(bus0.inst_sram_addr);
    if (bus1.inst_sram_en) bus1.inst_sram_rdata <= mem_data(bus1.inst_sram_addr);
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of DUT0 ----------------
  bit            m_run  = 1'b0;
  bit            m_pend = 1'b0;
  logic [AW-1:0] m_fpc  = RPC0;
  logic [AW-1:0] m_ppc  = RPC0;
  logic [AW-1:0] m_q[$];

  logic [AW-1:0] acc0[$];   // PCs decode accepted from DUT0
  logic [AW-1:0] acc1[$];   // PCs decode accepted from DUT1

  task automatic model_step();
    bit pop, en;
    if (rst) begin
      m_run = 1'b0; m_pend = 1'b0; m_fpc = RPC0; m_q.delete();
      return;
    end
    pop = (m_q.size() != 0) && bus0.id_ready && !bus0.redirect_valid;
    en  = m_run && !bus0.redirect_valid
          && (int'(m_q.size()) + int'(m_pend) - int'(pop) < DEPTH);
    if (bus0.redirect_valid) begin
      m_q.delete();
      m_pend = 1'b0;
      m_fpc  = {bus0.redirect_pc[AW-1:2], 2'b00};
    end else begin
      if (pop)    void'(m_q.pop_front());
      if (m_pend) m_q.push_back(m_ppc);
      if (en) begin
        m_ppc  = m_fpc;
        m_fpc  = m_fpc + 32'd4;
        m_pend = 1'b1;
      end else begin
        m_pend = 1'b0;
      end
    end
    m_run = 1'b1;
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    bit mv, mpop, men;
    @(negedge clk);
    mv   = (m_q.size() != 0) && !bus0.redirect_valid;
    mpop = mv && bus0.id_ready;
    men  = m_run && !bus0.redirect_valid
           && (int'(m_q.size()) + int'(m_pend) - int'(mpop) < DEPTH);
    check("sram_en", {63'd0, bus0.inst_sram_en}, {63'd0, men});
    check("sram_addr", {32'd0, bus0.inst_sram_addr}, {32'd0, m_fpc});
    check("if_valid", {63'd0, bus0.if_valid}, {63'd0, mv});
    if (mv) begin
      check("if_pc", {32'd0, bus0.if_pc}, {32'd0, m_q[0]});
      check("if_inst", {32'd0, bus0.if_inst}, {32'd0, mem_data(m_q[0])});
    end
    if (bus0.if_valid && bus0.id_ready && !bus0.redirect_valid) acc0.push_back(bus0.if_pc);
    if (bus1.if_valid && bus1.id_ready) begin
      acc1.push_back(bus1.if_pc);
      check("if_inst_wrap", {32'd0, bus1.if_inst}, {32'd0, mem_data(bus1.if_pc)});
    end
  end

  task automatic check_acc0(input string name, input int idx, input logic [AW-1:0] exp);
    logic [63:0] v = 64'hDEAD_0000_0000_0000;
    if (idx < acc0.size()) v = {32'd0, acc0[idx]};
    check(name, v, {32'd0, exp});
  endtask

  task automatic check_acc1(input string name, input int idx, input logic [AW-1:0] exp);
    logic [63:0] v = 64'hDEAD_0000_0000_0000;
    if (idx < acc1.size()) v = {32'd0, acc1[idx]};
    check(name, v, {32'd0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int first;
    int idx;
    int breaks;
    int stale;

    bus0.redirect_valid = 1'b0; bus0.redirect_pc = '0; bus0.id_ready = 1'b0;
    bus1.redirect_valid = 1'b0; bus1.redirect_pc = '0; bus1.id_ready = 1'b1;

    // Test 1: reset, release, stream
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_en", {63'd0, bus0.inst_sram_en}, 64'd0);
    check("rst_valid", {63'd0, bus0.if_valid}, 64'd0);
    check("rst_addr", {32'd0, bus0.inst_sram_addr}, {32'd0, RPC0});
    check("rst_addr_wrap", {32'd0, bus1.inst_sram_addr}, {32'd0, RPC1});
    rst = 1'b0;
    bus0.id_ready = 1'b1;
    first = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) check("idle_en", {63'd0, bus0.inst_sram_en}, 64'd0);
      if (k == 2) check("first_req", {31'd0, bus0.inst_sram_en, bus0.inst_sram_addr}, 64'h1_0000_0000);
      if (first == 0 && bus0.if_valid) first = k;
    end
    check("first_valid_cycle", 64'(first), 64'd4);
    check_acc0("t1_pc0", 0, 32'h0);
    check_acc0("t1_pc1", 1, 32'h4);
    check_acc0("t1_pc2", 2, 32'h8);
    check_acc0("t1_pc3", 3, 32'hC);

    // Test 2: back-pressure for 10 cycles; head is 0x24 (0x20 popped at this edge)
    @(posedge clk); #1 bus0.id_ready = 1'b0;
    @(negedge clk);
    check("bp_head_first", {32'd0, bus0.if_pc}, 64'h24);
    repeat (9) @(negedge clk);
    check("bp_en_low", {63'd0, bus0.inst_sram_en}, 64'd0);
    check("bp_valid", {63'd0, bus0.if_valid}, 64'd1);
    check("bp_head_stable", {32'd0, bus0.if_pc}, 64'h24);
    idx = acc0.size();
    @(posedge clk); #1 bus0.id_ready = 1'b1;
    repeat (8) @(negedge clk);
    check_acc0("bp_resume0", idx, 32'h24);
    check_acc0("bp_resume1", idx + 1, 32'h28);
    breaks = 0;
    for (int i = 1; i < acc0.size(); i++)
      if (acc0[i] != acc0[i-1] + 32'd4) breaks++;
    check("bp_contiguous", 64'(breaks), 64'd0);

    // Test 3: redirect to 0x1003 mid-stream (queue occupied, response pending)
    @(posedge clk); #1 bus0.redirect_valid = 1'b1; bus0.redirect_pc = 32'h0000_1003;
    @(negedge clk);
    check("redir_valid_low", {63'd0, bus0.if_valid}, 64'd0);
    check("redir_no_issue", {63'd0, bus0.inst_sram_en}, 64'd0);
    @(posedge clk); #1 bus0.redirect_valid = 1'b0;
    idx = acc0.size();
    @(negedge clk);
    check("redir_req", {31'd0, bus0.inst_sram_en, bus0.inst_sram_addr}, 64'h1_0000_1000);
    repeat (6) @(negedge clk);
    check_acc0("redir_first_pc", idx, 32'h1000);
    stale = 0;
    for (int i = idx; i < acc0.size(); i++)
      if (acc0[i] < 32'h1000) stale++;
    check("redir_no_stale", 64'(stale), 64'd0);

    // Test 4: back-to-back redirects, last wins
    @(posedge clk); #1 bus0.redirect_valid = 1'b1; bus0.redirect_pc = 32'h200;
    @(posedge clk); #1 bus0.redirect_pc = 32'h300;
    @(posedge clk); #1 bus0.redirect_valid = 1'b0;
    idx = acc0.size();
    @(negedge clk);
    check("b2b_req", {31'd0, bus0.inst_sram_en, bus0.inst_sram_addr}, 64'h1_0000_0300);
    repeat (6) @(negedge clk);
    check_acc0("b2b_first_pc", idx, 32'h300);
    check_acc0("b2b_second_pc", idx + 1, 32'h304);

    // Test 5 (wrap instance): collected since the first release
    check_acc1("wrap_pc0", 0, 32'hFFFF_FFF8);
    check_acc1("wrap_pc1", 1, 32'hFFFF_FFFC);
    check_acc1("wrap_pc2", 2, 32'h0000_0000);
    check_acc1("wrap_pc3", 3, 32'h0000_0004);

    // Test 6: asynchronous reset between edges
    @(posedge clk); #3 rst = 1'b1;
    #1;
    check("async_en", {63'd0, bus0.inst_sram_en}, 64'd0);
    check("async_valid", {63'd0, bus0.if_valid}, 64'd0);
    check("async_addr", {32'd0, bus0.inst_sram_addr}, {32'd0, RPC0});
    check("async_addr_wrap", {32'd0, bus1.inst_sram_addr}, {32'd0, RPC1});
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idx = acc0.size();
    repeat (10) @(negedge clk);
    check_acc0("restart_pc0", idx, 32'h0);
    check_acc0("restart_pc1", idx + 1, 32'h4);
    check_acc0("restart_pc2", idx + 2, 32'h8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
